// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// Holds ALU inputs for slow ops, registers the result/NZCV and owns the flag register.
module alu_scheduler #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SLOW_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [3:0]            req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_setflags,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [3:0]            req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_setflags,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [3:0]            flags,
  output logic [3:0]            alu_control,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  alu_carry_in,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_v
);

  localparam int unsigned CNT_W = (SLOW_CYCLES > 1) ? $clog2(SLOW_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  ptr_q;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  sf_q, id_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  win0, win1, accept, capture, sel_slow;
  logic [3:0]            sel_op;

  // ptr_q is the requester granted last; on a tie the other one wins
  assign win0     = req0_valid && (!req1_valid || ptr_q);
  assign win1     = req1_valid && (!req0_valid || !ptr_q);
  assign accept   = (state_q == IDLE) && (win0 || win1);
  assign capture  = (state_q == EXEC) && (cnt_q == '0);
  assign sel_op   = win1 ? req1_op : req0_op;
  assign sel_slow = (sel_op == 4'd9) || (sel_op == 4'd10) || (sel_op == 4'd11);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_q == IDLE) && reset) begin
      req0_ready = win0;
      req1_ready = win1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q      <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sf_q       <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flags      <= '0;
    end else begin
      rsp_valid <= capture;
      if (accept) begin
        ptr_q <= win1;
        id_q  <= win1;
        op_q  <= sel_op;
        a_q   <= win1 ? req1_a : req0_a;
        b_q   <= win1 ? req1_b : req0_b;
        sf_q  <= win1 ? req1_setflags : req0_setflags;
        cnt_q <= sel_slow ? CNT_W'(SLOW_CYCLES - 1) : '0;
      end else if ((state_q == EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // a flag write here only reaches alu_carry_in for later ops
      if (capture) begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_n, alu_z, alu_c, alu_v};
        rsp_id     <= id_q;
        if (sf_q) flags <= {alu_n, alu_z, alu_c, alu_v};
      end
    end
  end

  assign alu_control  = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_carry_in = flags[1];

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler with a behavioural ALU model.
module tb_alu_scheduler;

  logic        clock, reset;
  logic        req0_valid, req0_ready, req0_setflags;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_setflags;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags, flags, alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_carry_in, alu_n, alu_z, alu_c, alu_v;
  logic [32:0] sum;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  alu_scheduler #(.DATA_WIDTH(32), .SLOW_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_setflags(req0_setflags),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_setflags(req1_setflags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .flags(flags), .alu_control(alu_control),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v)
  );

  always #5 clock = ~clock;

  // ALU model: 1 ADC, 2 ADD, 5 SUB, 9 MUL, 10 DIV, 11 MOD, 12 pass B, else pass A
  always_comb begin
    sum        = '0;
    alu_result = alu_a;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    case (alu_control)
      4'd1, 4'd2: begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_control == 4'd1) ? 33'(alu_carry_in) : 33'd0);
        alu_result = sum[31:0];
        alu_c      = sum[32];
        alu_v      = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
      end
      4'd5: begin
        alu_result = alu_a - alu_b;
        alu_c      = (alu_a >= alu_b);
        alu_v      = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      4'd9:  alu_result = alu_a * alu_b;
      4'd10: begin alu_result = (alu_b == 0) ? 32'd0 : alu_a / alu_b; alu_v = (alu_b == 0); end
      4'd11: begin alu_result = (alu_b == 0) ? 32'd0 : alu_a % alu_b; alu_v = (alu_b == 0); end
      4'd12: alu_result = alu_b;
      default: alu_result = alu_a;
    endcase
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one op, hold until ready, then count negedges from accept to rsp_valid.
  task automatic do_op(input logic id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sf, output int latency);
    int w;
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_setflags = sf;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_setflags = sf;
    end
    w = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && w < 10) begin
      @(negedge clock); #1; w++;
    end
    check("accept", 32'(id ? req1_ready : req0_ready), 32'd1);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    latency = 1;
    while (!rsp_valid && latency < 20) begin
      @(negedge clock); latency++;
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_setflags = 1'b0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_setflags = 1'b0;

    // reset state
    @(negedge clock);
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_ctrl", 32'(alu_control), 32'd0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // 1: ADD 5+7 with setflags
    do_op(1'b0, 4'd2, 32'd5, 32'd7, 1'b1, lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_id", 32'(rsp_id), 32'd0);
    check("t1_result", rsp_result, 32'd12);
    check("t1_rsp_flags", 32'(rsp_flags), 32'h0);
    check("t1_flags", 32'(flags), 32'h0);
    @(negedge clock);
    check("t1_one_cycle", 32'(rsp_valid), 32'd0);

    // 2: both continuously valid after reset -> 0,1,0,1 every 3 cycles
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'd1;  req0_b = 32'd1;  req0_setflags = 1'b0;
    req1_valid = 1'b1; req1_op = 4'd2; req1_a = 32'd10; req1_b = 32'd20; req1_setflags = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("t2_ready0", 32'(((c % 3) == 0) && (req0_ready != 1'b0)), 32'(((c % 3) == 0) && (((c / 3) % 2) == 0)));
      check("t2_ready1", 32'(req1_ready), 32'(((c % 3) == 0) && (((c / 3) % 2) == 1)));
      check("t2_rsp_valid", 32'(rsp_valid), 32'((c % 3) == 2));
      if ((c % 3) == 2) begin
        check("t2_rsp_id", 32'(rsp_id), 32'((c / 3) % 2));
        check("t2_result", rsp_result, (((c / 3) % 2) == 0) ? 32'd2 : 32'd30);
      end
      @(negedge clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);

    // 3: ADD wraps to zero with carry, then ADC consumes the carry
    do_op(1'b0, 4'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, lat);
    check("t3_add_result", rsp_result, 32'd0);
    check("t3_add_rsp_flags", 32'(rsp_flags), 32'b0110);
    check("t3_add_flags", 32'(flags), 32'b0110);
    @(negedge clock);
    check("t3_carry_in", 32'(alu_carry_in), 32'd1);
    do_op(1'b0, 4'd1, 32'd0, 32'd0, 1'b0, lat);
    check("t3_adc_result", rsp_result, 32'd1);
    check("t3_adc_flags", 32'(flags), 32'b0110);
    @(negedge clock);

    // 5: SUB 3-5 without setflags leaves the flag register alone
    do_op(1'b0, 4'd5, 32'd3, 32'd5, 1'b0, lat);
    check("t5_latency", 32'(lat), 32'd2);
    check("t5_result", rsp_result, 32'hFFFF_FFFE);
    check("t5_rsp_flags", 32'(rsp_flags), 32'b1000);
    check("t5_flags", 32'(flags), 32'b0110);
    @(negedge clock);

    // 4: DIV 100/7 holds ALU inputs for 4 cycles
    req1_valid = 1'b1; req1_op = 4'd10; req1_a = 32'd100; req1_b = 32'd7; req1_setflags = 1'b0;
    #1;
    check("t4_accept", 32'(req1_ready), 32'd1);
    @(negedge clock);
    req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t4_hold_a", alu_a, 32'd100);
      check("t4_hold_b", alu_b, 32'd7);
      check("t4_hold_ctrl", 32'(alu_control), 32'd10);
      check("t4_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clock);
    end
    check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t4_result", rsp_result, 32'd14);
    check("t4_id", 32'(rsp_id), 32'd1);
    @(negedge clock);
    do_op(1'b0, 4'd10, 32'd9, 32'd0, 1'b0, lat);
    check("t4_div0_latency", 32'(lat), 32'd5);
    check("t4_div0_result", rsp_result, 32'd0);
    check("t4_div0_flags", 32'(rsp_flags), 32'b0101);
    @(negedge clock);

    // 6: reset in the second EXEC cycle of a DIV discards it
    req0_valid = 1'b1; req0_op = 4'd10; req0_a = 32'd50; req0_b = 32'd5; req0_setflags = 1'b1;
    #1;
    check("t6_accept", 32'(req0_ready), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t6_rst_ready", 32'(req0_ready), 32'd0);
    check("t6_rst_flags", 32'(flags), 32'd0);
    check("t6_rst_result", rsp_result, 32'd0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check("t6_flags", 32'(flags), 32'd0);
    do_op(1'b1, 4'd2, 32'd1, 32'd1, 1'b0, lat);
    check("t6_latency", 32'(lat), 32'd2);
    check("t6_id", 32'(rsp_id), 32'd1);
    check("t6_result", rsp_result, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
